// File: rtl/nano_fetch_unit_pkg.sv
// Shared constants, the instruction-buffer entry type and PC helpers for the
// nano fetch front-end.
package nano_fetch_unit_pkg;

    localparam int          FETCH_DEPTH_DEFAULT = 4;
    localparam logic [31:0] INST_BUBBLE         = 32'h0000_0000;
    localparam logic [31:0] PC_STEP             = 32'h0000_0004;
    localparam logic [31:0] PC_ALIGN_MASK       = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/nano_fetch_fifo.sv
// Synchronous FIFO with flush. Holds PC tags and buffered instructions.
// Flush beats push/pop; a pop on empty or a push on full-without-pop is ignored.
module nano_fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [CW-1:0]    count_r;
    logic             pop_ok_s;
    logic             push_ok_s;

    // Qualify requests against occupancy; a full FIFO may still push when popping.
    always_comb begin
        pop_ok_s  = pop && (count_r != CW'(0));
        push_ok_s = push && ((count_r != CW'(DEPTH)) || pop_ok_s);
    end

    // Pointer and occupancy state.
    always_ff @(posedge i_clk) begin
        if (i_rst || flush) begin
            rd_ptr_r <= AW'(0);
            wr_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_r + CW'(push_ok_s) - CW'(pop_ok_s);
        end
    end

    // Storage array; the head is read combinationally so a same-edge overwrite is safe.
    always_ff @(posedge i_clk) begin
        if (push_ok_s && !flush && !i_rst) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/nano_fetch_unit.sv
// Instruction fetch front-end: issues sequential word fetches under a credit
// limit, tags in-order responses with their PC and buffers them for decode.
module nano_fetch_unit
    import nano_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = FETCH_DEPTH_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_mem_req_valid,
    output logic [31:0] o_mem_req_addr,
    input  logic        i_mem_req_ready,
    input  logic        i_mem_rsp_valid,
    input  logic [31:0] i_mem_rsp_data,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_inst_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    input  logic        i_inst_ready
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 1;

    logic [31:0]   fetch_pc_r;
    logic [CW-1:0] drop_r;

    // live is the occupancy of the tag queue: one tag per response still to be kept.
    logic [CW-1:0] live_s;
    logic [CW-1:0] inst_count_s;
    logic [31:0]   tag_pc_s;
    fetch_entry_t  inst_head_s;
    fetch_entry_t  inst_push_data_s;

    logic [SW-1:0] live_drop_sum_s;
    logic [SW-1:0] live_count_sum_s;
    logic [SW-1:0] drop_next_s;
    logic          credit_s;
    logic          req_fire_s;
    logic          rsp_fire_s;
    logic          rsp_drop_s;
    logic          rsp_keep_s;
    logic          pop_fire_s;
    logic          inst_valid_s;

    // Credit, handshake and response classification, all from registered state.
    always_comb begin
        live_drop_sum_s  = SW'(live_s) + SW'(drop_r);
        live_count_sum_s = SW'(live_s) + SW'(inst_count_s);
        credit_s         = (live_drop_sum_s < SW'(DEPTH)) && (live_count_sum_s < SW'(DEPTH));
        req_fire_s       = o_mem_req_valid && i_mem_req_ready;
        rsp_fire_s       = i_mem_rsp_valid && ((live_s != CW'(0)) || (drop_r != CW'(0)));
        rsp_drop_s       = rsp_fire_s && (drop_r != CW'(0));
        rsp_keep_s       = rsp_fire_s && (drop_r == CW'(0));
        inst_valid_s     = (inst_count_s != CW'(0));
        pop_fire_s       = inst_valid_s && i_inst_ready;
        drop_next_s      = SW'(drop_r) + SW'(live_s) + SW'(req_fire_s) - SW'(rsp_fire_s);
        inst_push_data_s = '{pc: tag_pc_s, inst: i_mem_rsp_data};
    end

    assign o_mem_req_valid = !i_rst && credit_s;
    assign o_mem_req_addr  = fetch_pc_r;

    // Fetch PC: redirect overrides the sequential advance.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_pc_r <= RESET_PC;
        end else if (i_redirect) begin
            fetch_pc_r <= align_pc(i_redirect_pc);
        end else if (req_fire_s) begin
            fetch_pc_r <= fetch_pc_r + PC_STEP;
        end else begin
            fetch_pc_r <= fetch_pc_r;
        end
    end

    // Discard counter: a redirect turns every outstanding request, including one
    // accepted this cycle and minus one answered this cycle, into a discard.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            drop_r <= CW'(0);
        end else if (i_redirect) begin
            drop_r <= CW'(drop_next_s);
        end else if (rsp_drop_s) begin
            drop_r <= drop_r - CW'(1);
        end else begin
            drop_r <= drop_r;
        end
    end

    nano_fetch_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .push  (req_fire_s && !i_redirect),
        .pop   (rsp_keep_s && !i_redirect),
        .flush (i_redirect),
        .din   (fetch_pc_r),
        .dout  (tag_pc_s),
        .count (live_s)
    );

    nano_fetch_fifo #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_inst_fifo (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .push  (rsp_keep_s && !i_redirect),
        .pop   (pop_fire_s && !i_redirect),
        .flush (i_redirect),
        .din   (inst_push_data_s),
        .dout  (inst_head_s),
        .count (inst_count_s)
    );

    // Decode sees a deterministic bubble whenever the buffer is empty.
    assign o_inst_valid = inst_valid_s;
    assign o_inst       = inst_valid_s ? inst_head_s.inst : INST_BUBBLE;
    assign o_pc         = inst_valid_s ? inst_head_s.pc   : INST_BUBBLE;

endmodule

// File: tb/tb_nano_fetch_unit.sv
// Directed-vector and model-checked bench for nano_fetch_unit (DEPTH 4,
// RESET_PC 0); the memory model returns the request address as data.
module tb_nano_fetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        o_mem_req_valid;
    logic [31:0] o_mem_req_addr;
    logic        i_mem_req_ready = 1'b0;
    logic        i_mem_rsp_valid = 1'b0;
    logic [31:0] i_mem_rsp_data  = 32'h0;
    logic        i_redirect      = 1'b0;
    logic [31:0] i_redirect_pc   = 32'h0;
    logic        o_inst_valid;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic        i_inst_ready    = 1'b0;

    nano_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .o_mem_req_valid(o_mem_req_valid), .o_mem_req_addr(o_mem_req_addr),
        .i_mem_req_ready(i_mem_req_ready), .i_mem_rsp_valid(i_mem_rsp_valid),
        .i_mem_rsp_data(i_mem_rsp_data), .i_redirect(i_redirect),
        .i_redirect_pc(i_redirect_pc), .o_inst_valid(o_inst_valid),
        .o_inst(o_inst), .o_pc(o_pc), .i_inst_ready(i_inst_ready)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        logic        stale;
    } pend_t;

    typedef struct {
        logic        rst;
        logic        inst_ready;
        logic        mem_ready;
        logic        exp_rv;
        logic [31:0] exp_addr;
        logic        exp_iv;
        logic [31:0] exp_pc;
    } vec_t;

    pend_t       pend[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_fetch = RESET_PC;
    int          cyc = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          n_tests = 0;
    int          n_fail = 0;
    vec_t        vecs[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_mem();
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            i_mem_rsp_valid = 1'b1;
            i_mem_rsp_data  = pend[0].addr;
        end else begin
            i_mem_rsp_valid = 1'b0;
            i_mem_rsp_data  = 32'h0;
        end
    endtask

    // One clock: sample handshakes, advance the edge, update memory and reference model.
    task automatic tick();
        logic        req_fire, rsp, pop, redir, rst;
        logic [31:0] rpc, raddr;
        pend_t       h;
        #1;
        rst      = i_rst;
        redir    = i_redirect;
        rpc      = i_redirect_pc;
        req_fire = o_mem_req_valid && i_mem_req_ready;
        raddr    = o_mem_req_addr;
        rsp      = i_mem_rsp_valid;
        pop      = o_inst_valid && i_inst_ready;
        @(posedge i_clk);
        #1;
        cyc++;
        if (rst) begin
            pend.delete();
            exp_q.delete();
            exp_fetch = RESET_PC;
        end else begin
            if (pop && !redir && exp_q.size() > 0) void'(exp_q.pop_front());
            if (rsp && pend.size() > 0) begin
                h = pend.pop_front();
                if (!redir && !h.stale) exp_q.push_back(h.addr);
            end
            if (req_fire) begin
                h.addr  = raddr;
                h.due   = cyc + $urandom_range(lat_min, lat_max) - 1;
                h.stale = 1'b0;
                pend.push_back(h);
            end
            if (redir) begin
                foreach (pend[i]) pend[i].stale = 1'b1;
                exp_q.delete();
                exp_fetch = rpc & 32'hFFFF_FFFC;
            end else if (req_fire) begin
                exp_fetch = exp_fetch + 32'h4;
            end
        end
        drive_mem();
    endtask

    task automatic check_model(input string tag);
        int          live;
        logic        exp_rv;
        logic [31:0] hp;
        live = 0;
        foreach (pend[i]) if (!pend[i].stale) live++;
        exp_rv = !i_rst && (pend.size() < DEPTH) && ((live + exp_q.size()) < DEPTH);
        hp = (exp_q.size() > 0) ? exp_q[0] : 32'h0;
        chk({tag, "/req_valid"}, 32'(o_mem_req_valid), 32'(exp_rv));
        chk({tag, "/req_addr"}, o_mem_req_addr, exp_fetch);
        chk({tag, "/inst_valid"}, 32'(o_inst_valid), 32'(exp_q.size() > 0));
        chk({tag, "/pc"}, o_pc, hp);
        chk({tag, "/inst"}, o_inst, hp);
        chk({tag, "/outstanding_le_depth"}, 32'(pend.size() <= DEPTH), 32'd1);
        chk({tag, "/count_le_depth"}, 32'(exp_q.size() <= DEPTH), 32'd1);
    endtask

    task automatic do_reset();
        i_rst      = 1'b1;
        i_redirect = 1'b0;
        tick();
        tick();
        #1;
        chk("rst/req_valid", 32'(o_mem_req_valid), 32'd0);
        chk("rst/req_addr", o_mem_req_addr, RESET_PC);
        chk("rst/inst_valid", 32'(o_inst_valid), 32'd0);
        chk("rst/inst", o_inst, 32'h0);
        chk("rst/pc", o_pc, 32'h0);
        i_rst = 1'b0;
    endtask

    // Bounded wait for the next valid instruction, then check its PC.
    task automatic wait_valid(input string name, input logic [31:0] exp_pc);
        int t;
        t = 0;
        #1;
        while (!o_inst_valid && t < 20) begin
            tick();
            t++;
        end
        chk({name, "/valid"}, 32'(o_inst_valid), 32'd1);
        chk({name, "/pc"}, o_pc, exp_pc);
        chk({name, "/inst"}, o_inst, exp_pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // rst, inst_ready, mem_ready, exp req_valid, exp addr, exp inst_valid, exp pc
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h00};
        for (int k = 10; k < 16; k++) vecs[k] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 1'b1, 32'h00};
        vecs[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h00};
        vecs[17] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h04};
        vecs[18] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h08};
        vecs[19] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h18, 1'b1, 32'h0C};
        vecs[20] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};
        vecs[21] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h20, 1'b1, 32'h14};

        lat_min = 1;
        lat_max = 1;
        for (int k = 0; k < 22; k++) begin
            if (vecs[k].rst) do_reset();
            i_inst_ready    = vecs[k].inst_ready;
            i_mem_req_ready = vecs[k].mem_ready;
            #1;
            chk($sformatf("v%0d/req_valid", k), 32'(o_mem_req_valid), 32'(vecs[k].exp_rv));
            chk($sformatf("v%0d/req_addr", k), o_mem_req_addr, vecs[k].exp_addr);
            chk($sformatf("v%0d/inst_valid", k), 32'(o_inst_valid), 32'(vecs[k].exp_iv));
            chk($sformatf("v%0d/pc", k), o_pc, vecs[k].exp_iv ? vecs[k].exp_pc : 32'h0);
            chk($sformatf("v%0d/inst", k), o_inst, vecs[k].exp_iv ? vecs[k].exp_pc : 32'h0);
            tick();
        end

        // Latency 3, two requests in flight, redirect to an unaligned target.
        do_reset();
        lat_min = 3;
        lat_max = 3;
        i_inst_ready    = 1'b1;
        i_mem_req_ready = 1'b1;
        tick();
        tick();
        i_mem_req_ready = 1'b0;
        i_redirect      = 1'b1;
        i_redirect_pc   = 32'h0000_0103;
        #1;
        chk("r1/in_flight", pend.size(), 32'd2);
        tick();
        i_redirect      = 1'b0;
        i_mem_req_ready = 1'b1;
        #1;
        chk("r1/flushed_valid", 32'(o_inst_valid), 32'd0);
        chk("r1/new_addr", o_mem_req_addr, 32'h0000_0100);
        wait_valid("r1/first", 32'h0000_0100);
        tick();
        wait_valid("r1/second", 32'h0000_0104);

        // Redirect coinciding with a response and a request handshake.
        do_reset();
        lat_min = 1;
        lat_max = 1;
        i_inst_ready    = 1'b1;
        i_mem_req_ready = 1'b1;
        repeat (4) tick();
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h0000_0200;
        #1;
        chk("r2/req_valid", 32'(o_mem_req_valid), 32'd1);
        chk("r2/rsp_valid", 32'(i_mem_rsp_valid), 32'd1);
        tick();
        i_redirect = 1'b0;
        #1;
        chk("r2/flushed_valid", 32'(o_inst_valid), 32'd0);
        chk("r2/new_addr", o_mem_req_addr, 32'h0000_0200);
        wait_valid("r2/first", 32'h0000_0200);
        tick();
        wait_valid("r2/second", 32'h0000_0204);

        // Random backpressure, latency and redirects against the reference model.
        do_reset();
        lat_min = 1;
        lat_max = 5;
        for (int c = 0; c < 600; c++) begin
            i_mem_req_ready = ($urandom_range(0, 3) != 0);
            i_inst_ready    = ($urandom_range(0, 3) != 0);
            i_redirect      = ($urandom_range(0, 31) == 0);
            i_redirect_pc   = $urandom();
            #1;
            check_model("rnd");
            tick();
        end
        i_redirect = 1'b0;

        // Reset asserted with a full instruction buffer.
        do_reset();
        lat_min = 1;
        lat_max = 1;
        i_inst_ready    = 1'b0;
        i_mem_req_ready = 1'b1;
        repeat (10) tick();
        #1;
        chk("rm/full_valid", 32'(o_inst_valid), 32'd1);
        chk("rm/full_pc", o_pc, 32'h0);
        chk("rm/full_req_valid", 32'(o_mem_req_valid), 32'd0);
        i_rst = 1'b1;
        tick();
        #1;
        chk("rm/req_valid", 32'(o_mem_req_valid), 32'd0);
        chk("rm/req_addr", o_mem_req_addr, RESET_PC);
        chk("rm/inst_valid", 32'(o_inst_valid), 32'd0);
        chk("rm/inst", o_inst, 32'h0);
        chk("rm/pc", o_pc, 32'h0);
        i_rst = 1'b0;
        #1;
        chk("rm/restart_valid", 32'(o_mem_req_valid), 32'd1);
        chk("rm/restart_addr", o_mem_req_addr, RESET_PC);
        i_inst_ready = 1'b1;
        wait_valid("rm/first", 32'h0);
        tick();
        wait_valid("rm/second", 32'h4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
